// File: rtl/raster_window_capture_pkg.sv
// Shared constants for the raster window capture block: window geometry, buffer sizing,
// FSM encodings and small helpers.
package raster_window_capture_pkg;

  localparam int X_WIDTH     = 10;
  localparam int Y_WIDTH     = 10;
  localparam int PIXEL_WIDTH = 9;
  localparam int WIN_X0      = 4;
  localparam int WIN_Y0      = 4;
  localparam int WIN_SIZE    = 28;
  localparam int ADDR_WIDTH  = 10;
  localparam int BUF_DEPTH   = WIN_SIZE * WIN_SIZE;

  localparam logic [X_WIDTH-1:0] X_LO   = X_WIDTH'(WIN_X0);
  localparam logic [X_WIDTH-1:0] X_HI   = X_WIDTH'(WIN_X0 + WIN_SIZE);
  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(WIN_X0 + WIN_SIZE - 1);
  localparam logic [Y_WIDTH-1:0] Y_LO   = Y_WIDTH'(WIN_Y0);
  localparam logic [Y_WIDTH-1:0] Y_HI   = Y_WIDTH'(WIN_Y0 + WIN_SIZE);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(WIN_Y0 + WIN_SIZE - 1);

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = ADDR_WIDTH'(BUF_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(WIN_SIZE);
  // Row base of raster line 0, modulo 2^ADDR_WIDTH, so that line WIN_Y0 lands on zero.
  localparam logic [ADDR_WIDTH-1:0] ROW_BASE0 = ADDR_WIDTH'(0 - WIN_Y0 * WIN_SIZE);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/raster_window_capture_if.sv
// Stream, frame handshake and buffer read port between the raster source/consumer and the
// capture block.
interface raster_window_capture_if;
  import raster_window_capture_pkg::*;

  logic [X_WIDTH-1:0]     screen_x_pos;
  logic [Y_WIDTH-1:0]     screen_y_pos;
  logic [PIXEL_WIDTH-1:0] pixel_in;
  logic                   pixel_valid;
  logic                   frame_ready;
  logic                   frame_ack;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [PIXEL_WIDTH-1:0] rd_data;
  logic                   capturing;
  logic [7:0]             dropped_frames;

  modport master (
    output screen_x_pos, screen_y_pos, pixel_in, pixel_valid, frame_ack, rd_addr,
    input  frame_ready, rd_data, capturing, dropped_frames
  );

  modport slave (
    input  screen_x_pos, screen_y_pos, pixel_in, pixel_valid, frame_ack, rd_addr,
    output frame_ready, rd_data, capturing, dropped_frames
  );

endinterface

// File: rtl/raster_window_capture_window_buffer_ram.sv
// Window buffer: one write port, one registered read port; shaped for block RAM inference.
module window_buffer_ram
  import raster_window_capture_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   we,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [PIXEL_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [PIXEL_WIDTH-1:0] rd_data
);

  logic [PIXEL_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PIXEL_WIDTH-1:0] rd_data_d;
  logic [PIXEL_WIDTH-1:0] rd_data_q;

  // Array write; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read word selected by the current address.
  always_comb begin
    rd_data_d = mem_q[rd_addr];
  end

  // Output register of the read port.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= {PIXEL_WIDTH{1'b0}};
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/raster_window_capture.sv
// Captures a fixed square window of the camera raster into a buffer, flags the complete
// frame to the conv front end, and re-arms on acknowledge.
module raster_window_capture
  import raster_window_capture_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  raster_window_capture_if.slave  bus
);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]            dropped_q, dropped_d;
  logic                  frame_ready_q, frame_ready_d;
  logic                  capturing_q, capturing_d;
  logic [Y_WIDTH-1:0]    y_trk_q, y_trk_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;

  logic                  fs_s;
  logic                  iw_s;
  logic                  last_s;
  logic                  we_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;

  // Beat classification from the raw position.
  always_comb begin
    fs_s = bus.pixel_valid && (bus.screen_x_pos == {X_WIDTH{1'b0}}) &&
           (bus.screen_y_pos == {Y_WIDTH{1'b0}});
    iw_s = bus.pixel_valid &&
           (bus.screen_x_pos >= X_LO) && (bus.screen_x_pos < X_HI) &&
           (bus.screen_y_pos >= Y_LO) && (bus.screen_y_pos < Y_HI);
    last_s = iw_s && (bus.screen_x_pos == X_LAST) && (bus.screen_y_pos == Y_LAST);
  end

  // Row base follows the raster line by line, so the write address needs no multiplier.
  always_comb begin
    y_trk_d    = y_trk_q;
    row_base_d = row_base_q;
    if (bus.screen_y_pos == {Y_WIDTH{1'b0}}) begin
      y_trk_d    = {Y_WIDTH{1'b0}};
      row_base_d = ROW_BASE0;
    end else if (bus.screen_y_pos == (y_trk_q + Y_WIDTH'(1))) begin
      y_trk_d    = bus.screen_y_pos;
      row_base_d = row_base_q + ROW_STEP;
    end else begin
      y_trk_d    = y_trk_q;
      row_base_d = row_base_q;
    end
    wr_addr_s = row_base_d + ADDR_WIDTH'(bus.screen_x_pos - X_LO);
  end

  // Capture FSM, write counter and dropped-frame counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dropped_d = dropped_q;
    we_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fs_s) begin
          state_d = ST_CAPTURE;
          we_s    = iw_s;
          cnt_d   = iw_s ? ADDR_WIDTH'(1) : ADDR_WIDTH'(0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (fs_s) begin
          we_s  = iw_s;
          cnt_d = iw_s ? ADDR_WIDTH'(1) : ADDR_WIDTH'(0);
        end else if (iw_s) begin
          we_s  = 1'b1;
          cnt_d = cnt_q + ADDR_WIDTH'(1);
          if (last_s) begin
            // A frame missing any beat is discarded rather than handed on.
            state_d = (cnt_q == CNT_LAST) ? ST_READY : ST_IDLE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_READY: begin
        if (fs_s) begin
          dropped_d = sat_inc8(dropped_q);
        end else begin
          dropped_d = dropped_q;
        end
        if (bus.frame_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    frame_ready_d = (state_d == ST_READY);
    capturing_d   = (state_d == ST_CAPTURE);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {ADDR_WIDTH{1'b0}};
      dropped_q     <= 8'd0;
      frame_ready_q <= 1'b0;
      capturing_q   <= 1'b0;
      y_trk_q       <= {Y_WIDTH{1'b0}};
      row_base_q    <= ROW_BASE0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dropped_q     <= dropped_d;
      frame_ready_q <= frame_ready_d;
      capturing_q   <= capturing_d;
      y_trk_q       <= y_trk_d;
      row_base_q    <= row_base_d;
    end
  end

  window_buffer_ram u_buf (
    .clock   (clock),
    .reset   (reset),
    .we      (we_s),
    .wr_addr (wr_addr_s),
    .wr_data (bus.pixel_in),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

  assign bus.frame_ready    = frame_ready_q;
  assign bus.capturing      = capturing_q;
  assign bus.dropped_frames = dropped_q;

endmodule

// File: tb/tb_raster_window_capture.sv
// Directed bench for raster_window_capture: 36x36 raster frames, scoreboard on the read port
// and on frame_ready rise timing, direct checks on status outputs.
module tb_raster_window_capture;
  import raster_window_capture_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  raster_window_capture_if bus();

  raster_window_capture dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   cyc = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  logic fr_prev = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   exp_rise_q[$];
  int   exp_rd_q[$];

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) rd_vld <= rd_req;

  function automatic logic [8:0] pix(input int x, input int y, input int salt);
    int v;
    v = (y * 36 + x + salt) % 512;
    return v[8:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Scoreboard monitor: read data and frame_ready rise timing.
  always @(negedge clock) begin
    if (rd_vld) begin
      if (exp_rd_q.size() == 0) begin
        checks++;
        $display("FAIL rd_unexpected: got data %0d with no read outstanding", bus.rd_data);
      end else begin
        chk("rd_data", int'(bus.rd_data), exp_rd_q.pop_front());
      end
    end
    if (bus.frame_ready && !fr_prev) begin
      if (exp_rise_q.size() == 0) begin
        checks++;
        $display("FAIL frame_ready_spurious: rose at cycle %0d, required no rise", cyc);
      end else begin
        chk("frame_ready_rise_cycle", cyc, exp_rise_q.pop_front());
      end
    end
    fr_prev <= bus.frame_ready;
  end

  task automatic beat(input int x, input int y, input int salt,
                      input logic v, input logic ack, input logic rst);
    bus.screen_x_pos = 10'(x);
    bus.screen_y_pos = 10'(y);
    bus.pixel_in     = pix(x, y, salt);
    bus.pixel_valid  = v;
    bus.frame_ack    = ack;
    reset            = rst;
    @(posedge clock); #1;
  endtask

  task automatic raster(input int salt, input int first, input int stop,
                        input int drop_idx, input bit expect_done);
    for (int i = first; i < stop; i++) begin
      beat(i % 36, i / 36, salt, (i != drop_idx), 1'b0, 1'b0);
      if (expect_done && i == 31 * 36 + 31) exp_rise_q.push_back(cyc);
    end
  endtask

  task automatic rd(input int a, input int e);
    bus.pixel_valid = 1'b0;
    bus.frame_ack   = 1'b0;
    bus.rd_addr     = 10'(a);
    rd_req          = 1'b1;
    exp_rd_q.push_back(e);
    @(posedge clock); #1;
    rd_req = 1'b0;
  endtask

  task automatic ack();
    beat(35, 35, 0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.rd_addr = 10'd0;
    beat(35, 35, 0, 1'b0, 1'b0, 1'b1);
    beat(35, 35, 0, 1'b0, 1'b0, 1'b1);
    chk("reset_frame_ready", bus.frame_ready, 0);
    chk("reset_capturing", bus.capturing, 0);
    chk("reset_dropped", bus.dropped_frames, 0);
    chk("reset_rd_data", bus.rd_data, 0);

    // Clean frame straight out of reset.
    raster(0, 0, 1296, -1, 1'b1);
    chk("a_frame_ready", bus.frame_ready, 1);
    chk("a_capturing", bus.capturing, 0);
    rd(0, 148);
    rd(783, 123);
    rd(203, 407);

    // Three frames of different data while the buffer is held.
    for (int f = 0; f < 3; f++) raster(100, 0, 1296, -1, 1'b0);
    chk("held_dropped", bus.dropped_frames, 3);
    chk("held_frame_ready", bus.frame_ready, 1);
    rd(0, 148);
    rd(783, 123);

    ack();
    chk("ack_frame_ready", bus.frame_ready, 0);
    chk("ack_capturing", bus.capturing, 0);
    beat(0, 0, 200, 1'b1, 1'b0, 1'b0);
    chk("c_capturing_after_fs", bus.capturing, 1);
    raster(200, 1, 1296, -1, 1'b1);
    rd(0, 348);
    ack();

    // Missing beat at (10,10): frame discarded, next clean frame accepted.
    raster(300, 0, 1296, 10 * 36 + 10, 1'b0);
    chk("gap_frame_ready", bus.frame_ready, 0);
    chk("gap_capturing", bus.capturing, 0);
    raster(50, 0, 1296, -1, 1'b1);
    rd(783, 173);
    ack();

    // Torn frame: position jumps back to (0,0) mid-window.
    raster(400, 0, 20 * 36 + 15, -1, 1'b0);
    chk("torn_capturing_mid", bus.capturing, 1);
    beat(0, 0, 10, 1'b1, 1'b0, 1'b0);
    chk("torn_capturing_restart", bus.capturing, 1);
    raster(10, 1, 1296, -1, 1'b1);
    rd(0, 158);
    rd(458, 232);

    // Fill dropped counter, release, then reset mid-capture.
    raster(0, 0, 1296, -1, 1'b0);
    ack();
    raster(0, 0, 15 * 36 + 20, -1, 1'b0);
    beat(20, 15, 0, 1'b1, 1'b0, 1'b1);
    chk("rst_capturing", bus.capturing, 0);
    chk("rst_frame_ready", bus.frame_ready, 0);
    chk("rst_dropped", bus.dropped_frames, 0);
    raster(0, 15 * 36 + 21, 1296, -1, 1'b0);
    chk("rst_tail_capturing", bus.capturing, 0);
    raster(20, 0, 1296, -1, 1'b1);
    rd(0, 168);

    // Ack on the same beat as a frame start.
    beat(0, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("ackfs_frame_ready", bus.frame_ready, 0);
    chk("ackfs_capturing", bus.capturing, 0);
    chk("ackfs_dropped", bus.dropped_frames, 1);
    raster(0, 1, 1296, -1, 1'b0);
    chk("ackfs_tail_capturing", bus.capturing, 0);
    chk("ackfs_tail_frame_ready", bus.frame_ready, 0);
    raster(30, 0, 1296, -1, 1'b1);
    rd(783, 153);

    repeat (3) beat(35, 35, 0, 1'b0, 1'b0, 1'b0);
    chk("pending_rises", exp_rise_q.size(), 0);
    chk("pending_reads", exp_rd_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
